rf_spi_seq: RTL and testbench

RF_SPI_SEQ -- requirements
Module: rf_spi_seq

---
 rtl/rf_seq_pkg.sv | 16 +
 rtl/rf_cmd_fifo.sv | 35 +++
 rtl/rf_spi_seq.sv | 142 ++++++++++++++
 tb/tb_rf_spi_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: op/state enums, header constants and header builder for the radio SPI sequencer.
package rf_seq_pkg;
    typedef enum logic [1:0] {OP_SRD, OP_SWR, OP_LRD, OP_LWR} op_e;
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, TAIL, GAP, RESP} state_e;
    localparam int HDR_SHORT = 8;
    localparam int HDR_LONG = 16;
    localparam logic SHORT_FLAG = 1'b0;
    localparam logic LONG_FLAG = 1'b1;

    // Header returned left-aligned in 16 bits; short headers use the top byte only.
    function automatic logic [15:0] build_hdr(input logic lng, input logic wr, input logic [10:0] addr,
                                              input logic wide);
        return lng ? (wide ? {LONG_FLAG, addr, wr, 3'b000} : {LONG_FLAG, addr[9:0], wr, 4'b0000})
                   : {SHORT_FLAG, addr[5:0], wr, 8'h00};
    endfunction
endpackage

// File: rtl/rf_cmd_fifo.sv
// rf_cmd_fifo: command FIFO with wrap-bit pointers; ready is low during reset and while full.
module rf_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         ready,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic alive, full;
    assign empty = wp == rp;
    assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign ready = alive && !full;
    assign dout = mem[rp[AW-1:0]];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp <= '0;
            rp <= '0;
            alive <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (push && ready) wp <= wp + (AW+1)'(1);
            if (pop && !empty) rp <= rp + (AW+1)'(1);
        end
    always_ff @(posedge clk)
        if (push && ready) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/rf_spi_seq.sv
// rf_spi_seq: queued short/long register SPI sequencer for a radio; define RF_SEQ_INTR_EN for intr capture.
module rf_spi_seq #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH = 4,
    parameter int SCK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              sck,
    output logic              cs,
    output logic              sdi,
    input  logic              sdo,
    output logic              busy,
    input  logic              intr,
    output logic              intr_pending,
    input  logic              intr_clr
);
    import rf_seq_pkg::*;
    localparam int FW = HDR_LONG + DATA_W;
    localparam int EW = 2 + ADDR_W + DATA_W;
    localparam logic [15:0] D1 = 16'(SCK_DIV - 1);
    localparam logic [15:0] G1 = 16'(2 * SCK_DIV - 1);
    localparam logic [15:0] LAST_S = 16'(2 * (HDR_SHORT + DATA_W));
    localparam logic [15:0] LAST_L = 16'(2 * (HDR_LONG + DATA_W));
    localparam logic [15:0] HB_S = 16'(HDR_SHORT);
    localparam logic [15:0] HB_L = 16'(HDR_LONG);
    state_e state;
    op_e op;
    logic [EW-1:0] head;
    logic [FW-1:0] tx, frame;
    logic [DATA_W-1:0] rx, wdata;
    logic [15:0] cnt, half, hdr;
    logic empty, pop, rd, lng, long_op, wr_op;

    rf_cmd_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk(clk), .rst(rst), .push(cmd_valid && cmd_ready), .din({cmd_op, cmd_addr, cmd_data}),
        .pop(pop), .dout(head), .ready(cmd_ready), .empty(empty)
    );

    assign op = op_e'(head[EW-1 -: 2]);
    assign long_op = op == OP_LRD || op == OP_LWR;
    assign wr_op = op == OP_SWR || op == OP_LWR;
    assign hdr = build_hdr(long_op, wr_op, 11'(head[DATA_W +: ADDR_W]), ADDR_W == 11);
    assign wdata = wr_op ? head[DATA_W-1:0] : '0;
    assign frame = long_op ? {hdr, wdata} : {hdr[15:8], wdata, 8'h00};
    assign pop = state == IDLE && !empty;
    assign busy = state != IDLE || !empty;

    // Half-period 0 is the lead-in low; even half ends raise sck, odd ones drop it, half 2N is the trailing low.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cs <= 1'b1;
            sck <= 1'b0;
            sdi <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            tx <= '0;
            rx <= '0;
            cnt <= '0;
            half <= '0;
            rd <= 1'b0;
            lng <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    tx <= frame;
                    rd <= !wr_op;
                    lng <= long_op;
                    state <= LOAD;
                end
                LOAD: begin
                    cs <= 1'b0;
                    sdi <= tx[FW-1];
                    cnt <= '0;
                    half <= '0;
                    state <= SHIFT;
                end
                SHIFT: if (cnt != D1) cnt <= cnt + 16'd1;
                else begin
                    cnt <= '0;
                    half <= half + 16'd1;
                    if (half == (lng ? LAST_L : LAST_S)) begin
                        sdi <= 1'b0;
                        state <= TAIL;
                    end else if (!half[0]) begin
                        sck <= 1'b1;
                        if ((half >> 1) >= (lng ? HB_L : HB_S)) rx <= {rx[DATA_W-2:0], sdo};
                    end else begin
                        sck <= 1'b0;
                        sdi <= tx[FW-2];
                        tx <= tx << 1;
                    end
                end
                TAIL: if (cnt != D1) cnt <= cnt + 16'd1;
                else begin
                    cnt <= '0;
                    cs <= 1'b1;
                    state <= GAP;
                end
                GAP: if (cnt != G1) cnt <= cnt + 16'd1;
                else begin
                    cnt <= '0;
                    if (rd) begin
                        rsp_valid <= 1'b1;
                        rsp_data <= rx;
                    end
                    state <= rd ? RESP : IDLE;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end

`ifdef RF_SEQ_INTR_EN
    logic [2:0] isync;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            isync <= '0;
            intr_pending <= 1'b0;
        end else begin
            isync <= {isync[1:0], intr};
            intr_pending <= (isync[1] && !isync[2]) || (intr_pending && !intr_clr);
        end
`else
    logic unused_intr;
    assign unused_intr = intr ^ intr_clr;
    assign intr_pending = 1'b0;
`endif
endmodule

// File: tb/tb_rf_spi_seq.sv
// tb_rf_spi_seq: directed checks of framing, timing, back-pressure, reset and interrupt capture.
module tb_rf_spi_seq;
    logic clk = 0, rst = 0, cmd_valid = 0, rsp_ready = 0, sdo = 0, intr = 0, intr_clr = 0;
    logic [1:0] cmd_op = 0;
    logic [9:0] cmd_addr = 0;
    logic [7:0] cmd_data = 0;
    logic cmd_ready, rsp_valid, sck, cs, sdi, busy, intr_pending;
    logic [7:0] rsp_data;
    int total = 0, bad = 0, rises = 0, cs_low = 0, rsp_seen = 0, idx = 0;
    logic [31:0] cap = 0;
    logic [15:0] word = 16'h00A5;

    always #5 clk = ~clk;

    rf_spi_seq #(.DATA_W(8), .ADDR_W(10), .DEPTH(4), .SCK_DIV(2)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .sck(sck), .cs(cs), .sdi(sdi), .sdo(sdo), .busy(busy), .intr(intr),
        .intr_pending(intr_pending), .intr_clr(intr_clr)
    );

    always @(posedge sck) begin
        cap = {cap[30:0], sdi};
        rises++;
    end
    always @(negedge clk) begin
        if (!cs) cs_low++;
        if (rsp_valid) rsp_seen++;
    end
    // Radio model: first bit ready at cs fall, next bit after each sck fall.
    always @(negedge cs) begin
        idx = 15;
        sdo = word[15];
    end
    always @(negedge sck)
        if (idx > 0) begin
            idx--;
            sdo = word[idx];
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        rises = 0;
        cs_low = 0;
        rsp_seen = 0;
        cap = 0;
    endtask

    task automatic push(input logic [1:0] op, input logic [9:0] a, input logic [7:0] d, output logic acc);
        @(negedge clk);
        cmd_op = op;
        cmd_addr = a;
        cmd_data = d;
        cmd_valid = 1;
        acc = cmd_ready;
        @(posedge clk);
        #1 cmd_valid = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, rsp_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int nacc, n;
        #2 rst = 1;
        #1;
        chk("rst_cs", cs, 1);
        chk("rst_sck", sck, 0);
        chk("rst_sdi", sdi, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_rspd", rsp_data, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_intr", intr_pending, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1 chk("ready_rel", cmd_ready, 0);
        @(posedge clk);
        #1 chk("ready_post", cmd_ready, 1);

        clear();
        push(2'd1, 10'h02A, 8'h5C, acc);
        wait_idle("swr_idle");
        chk("swr_sdi", cap[15:0], 16'h555C);
        chk("swr_rises", rises, 16);
        chk("swr_cslow", cs_low, 68);
        chk("swr_norsp", rsp_seen, 0);

        clear();
        word = 16'h00A5;
        push(2'd0, 10'h031, 8'hFF, acc);
        wait_rsp("srd_rsp");
        chk("srd_hdr", cap[15:8], 8'h62);
        chk("srd_sdi0", cap[7:0], 8'h00);
        chk("srd_rises", rises, 16);
        chk("srd_data", rsp_data, 8'hA5);
        @(negedge clk);
        chk("srd_hold", rsp_data, 8'hA5);
        rsp_ready = 1;
        @(posedge clk);
        #1 chk("srd_drop", rsp_valid, 0);

        clear();
        push(2'd3, 10'h200, 8'h03, acc);
        wait_idle("lwr_idle");
        chk("lwr_sdi", cap[23:0], 24'hC01003);
        chk("lwr_rises", rises, 24);
        chk("lwr_cslow", cs_low, 100);
        chk("lwr_norsp", rsp_seen, 0);

        rsp_ready = 0;
        clear();
        push(2'd0, 10'h011, 8'h00, acc);
        wait_rsp("bp_rsp");
        clear();
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            push(2'd1, 10'(i), 8'(8'h10 + i), acc);
            nacc += int'(acc);
        end
        chk("bp_accept", nacc, 4);
        chk("bp_last", acc, 0);
        chk("bp_ready", cmd_ready, 0);
        repeat (20) @(negedge clk);
        chk("bp_nosck", rises, 0);
        chk("bp_busy", busy, 1);

        rsp_ready = 1;
        n = 0;
        while (rises < 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_rise5", rises, 5);
        rst = 1;
        #1;
        chk("mid_cs", cs, 1);
        chk("mid_sck", sck, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ready", cmd_ready, 0);
        chk("mid_rspv", rsp_valid, 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1 chk("mid_ready1", cmd_ready, 1);
        repeat (40) @(negedge clk);
        chk("mid_flush", rises, 5);
        chk("mid_idle", busy, 0);

`ifdef RF_SEQ_INTR_EN
        @(negedge clk);
        intr = 1;
        @(negedge clk);
        intr = 0;
        repeat (2) @(posedge clk);
        #1 chk("irq_set", intr_pending, 1);
        @(negedge clk);
        intr_clr = 1;
        @(negedge clk);
        intr_clr = 0;
        chk("irq_clr", intr_pending, 0);
        @(negedge clk);
        intr = 1;
        @(negedge clk);
        intr = 0;
        @(negedge clk);
        intr_clr = 1;
        @(negedge clk);
        intr_clr = 0;
        chk("irq_pre", intr_pending, 1);
        @(negedge clk);
        intr = 1;
        @(negedge clk);
        intr = 0;
        @(negedge clk);
        intr_clr = 1;
        @(negedge clk);
        intr_clr = 0;
        chk("irq_race", intr_pending, 1);
`else
        @(negedge clk);
        intr = 1;
        @(negedge clk);
        intr = 0;
        repeat (5) @(negedge clk);
        chk("irq_off", intr_pending, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
